// File: rtl/life_pkg.sv
// Shared constants for the Game-of-Life generation sequencer: FSM state codes,
// run status codes, cell timing, and the per-state decode of the registered control outputs.
package life_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RST  = 3'd1;
    localparam logic [2:0] ST_SEED = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [1:0] STAT_NONE    = 2'b00;
    localparam logic [1:0] STAT_LIMIT   = 2'b01;
    localparam logic [1:0] STAT_EXTINCT = 2'b10;
    localparam logic [1:0] STAT_STABLE  = 2'b11;

    localparam int unsigned LIFE_PHASE_LEN   = 7;
    localparam int unsigned LIFE_CELL_PERIOD = LIFE_PHASE_LEN;

    typedef struct packed {
        logic cell_nrst;
        logic seed_en;
        logic busy;
    } ctrl_t;

    // Control outputs are registered from the next state so they line up with r_state.
    function automatic ctrl_t state_ctrl(input logic [2:0] st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_RST: begin
                c.busy = 1'b1;
            end
            ST_SEED: begin
                c.cell_nrst = 1'b1;
                c.seed_en   = 1'b1;
                c.busy      = 1'b1;
            end
            ST_RUN: begin
                c.cell_nrst = 1'b1;
                c.busy      = 1'b1;
            end
            ST_DONE: begin
                c.cell_nrst = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/life_snap_buf.sv
// Single-entry valid/ready snapshot holding register. A capture into a still-valid,
// un-accepted entry overwrites it and raises a sticky drop flag.
module life_snap_buf #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned GEN_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cap,
    input  logic [DATA_W-1:0] i_cap_data,
    input  logic [GEN_W-1:0]  i_cap_gen,
    input  logic              i_ready,
    input  logic              i_clr_drop,
    output logic [DATA_W-1:0] o_data,
    output logic [GEN_W-1:0]  o_gen,
    output logic              o_valid,
    output logic              o_drop
);

    logic [DATA_W-1:0] r_data;
    logic [GEN_W-1:0]  r_gen;
    logic              r_valid;
    logic              r_drop;
    logic              w_hs;

    assign w_hs = r_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= '0;
            r_gen   <= '0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            if (i_cap) begin
                r_data  <= i_cap_data;
                r_gen   <= i_cap_gen;
                r_valid <= 1'b1;
                // Overwriting an entry nobody took this cycle loses a snapshot.
                if (r_valid && !w_hs) begin
                    r_drop <= 1'b1;
                end
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (i_clr_drop) begin
                r_drop <= 1'b0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_gen   = r_gen;
    assign o_valid = r_valid;
    assign o_drop  = r_drop;

endmodule

// File: rtl/life_gen_sequencer.sv
// Run sequencer for a flat Game-of-Life cell array: owns the array reset, opens the seed
// window, tracks the generation period, snapshots each generation and stops on end conditions.
module life_gen_sequencer
    import life_pkg::*;
#(
    parameter int unsigned N_CELLS   = 64,
    parameter int unsigned PHASE_LEN = LIFE_PHASE_LEN,
    parameter int unsigned RST_CYC   = 2,
    parameter int unsigned GEN_W     = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [GEN_W-1:0]   i_gen_limit,
    input  logic [N_CELLS-1:0] i_alive_in,
    output logic               o_cell_nrst,
    output logic               o_seed_en,
    output logic               o_busy,
    output logic [GEN_W-1:0]   o_gen_cnt,
    output logic [N_CELLS-1:0] o_snap_data,
    output logic [GEN_W-1:0]   o_snap_gen,
    output logic               o_snap_valid,
    input  logic               i_snap_ready,
    output logic               o_snap_drop,
    output logic [1:0]         o_status
);

    localparam int unsigned PH_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam int unsigned RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASE_LEN - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_d;
    ctrl_t              r_ctrl;
    ctrl_t              w_ctrl_d;
    logic [PH_W-1:0]    r_phase;
    logic [RC_W-1:0]    r_rst_cnt;
    logic [GEN_W-1:0]   r_cap_idx;
    logic [GEN_W-1:0]   r_gen_cnt;
    logic [1:0]         r_status;
    logic [N_CELLS-1:0] r_prev;

    logic               w_start_ok;
    logic               w_capture;
    logic               w_extinct;
    logic               w_stable;
    logic               w_limit;
    logic               w_stop;
    logic [1:0]         w_stop_status;

    always_comb begin
        w_start_ok = i_start && !i_abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_capture  = (r_state == ST_RUN) && (r_phase == '0) && !i_abort;
        w_extinct  = (i_alive_in == '0);
        w_stable   = (i_alive_in == r_prev);
        w_limit    = (i_gen_limit != '0) && (r_cap_idx == i_gen_limit);
        // Capture 0 is the seed itself and never ends a run.
        w_stop     = w_capture && (r_cap_idx != '0) && (w_extinct || w_stable || w_limit);
        if (w_extinct) begin
            w_stop_status = STAT_EXTINCT;
        end else if (w_stable) begin
            w_stop_status = STAT_STABLE;
        end else begin
            w_stop_status = STAT_LIMIT;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_d = ST_RST;
                end
            end
            ST_RST: begin
                if (i_abort) begin
                    w_state_d = ST_IDLE;
                end else if (r_rst_cnt == RC_LAST) begin
                    w_state_d = ST_SEED;
                end
            end
            ST_SEED: begin
                w_state_d = i_abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_state_d = ST_IDLE;
                end else if (w_stop) begin
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_abort) begin
                    w_state_d = ST_IDLE;
                end else if (w_start_ok) begin
                    w_state_d = ST_RST;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        w_ctrl_d = state_ctrl(w_state_d);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_ctrl    <= '0;
            r_phase   <= '0;
            r_rst_cnt <= '0;
            r_cap_idx <= '0;
            r_gen_cnt <= '0;
            r_status  <= STAT_NONE;
            r_prev    <= '0;
        end else begin
            r_state <= w_state_d;
            r_ctrl  <= w_ctrl_d;

            if (w_start_ok) begin
                r_phase   <= '0;
                r_rst_cnt <= '0;
                r_cap_idx <= '0;
                r_gen_cnt <= '0;
                r_status  <= STAT_NONE;
            end

            if (r_state == ST_RST) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end

            if (r_state == ST_SEED) begin
                r_phase <= '0;
            end else if (r_state == ST_RUN) begin
                r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
            end

            if (w_capture) begin
                r_prev <= i_alive_in;
                // Saturating index keeps unlimited runs going at the all-ones generation.
                if (r_cap_idx != '1) begin
                    r_cap_idx <= r_cap_idx + 1'b1;
                end
                if (r_cap_idx != '0) begin
                    r_gen_cnt <= r_cap_idx;
                end
            end

            if (w_stop) begin
                r_status <= w_stop_status;
            end
        end
    end

    life_snap_buf #(
        .DATA_W (N_CELLS),
        .GEN_W  (GEN_W)
    ) u_snap_buf (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_cap      (w_capture),
        .i_cap_data (i_alive_in),
        .i_cap_gen  (r_cap_idx),
        .i_ready    (i_snap_ready),
        .i_clr_drop (w_start_ok),
        .o_data     (o_snap_data),
        .o_gen      (o_snap_gen),
        .o_valid    (o_snap_valid),
        .o_drop     (o_snap_drop)
    );

    assign o_cell_nrst = r_ctrl.cell_nrst;
    assign o_seed_en   = r_ctrl.seed_en;
    assign o_busy      = r_ctrl.busy;
    assign o_gen_cnt   = r_gen_cnt;
    assign o_status    = r_status;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench for life_gen_sequencer: an 8x8 Life model supplies each generation, and expected
// timing/status come from cycle arithmetic over the generation list.
module tb_life_gen_sequencer;

    localparam int MAXG = 16;
    localparam int PL   = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] gen_limit;
    logic [63:0] alive_in;
    logic        cell_nrst;
    logic        seed_en;
    logic        busy;
    logic [15:0] gen_cnt;
    logic [63:0] snap_data;
    logic [15:0] snap_gen;
    logic        snap_valid;
    logic        snap_ready;
    logic        snap_drop;
    logic [1:0]  status;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] gens [MAXG];

    life_gen_sequencer #(
        .N_CELLS   (64),
        .PHASE_LEN (PL),
        .RST_CYC   (2),
        .GEN_W     (16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_abort      (abort),
        .i_gen_limit  (gen_limit),
        .i_alive_in   (alive_in),
        .o_cell_nrst  (cell_nrst),
        .o_seed_en    (seed_en),
        .o_busy       (busy),
        .o_gen_cnt    (gen_cnt),
        .o_snap_data  (snap_data),
        .o_snap_gen   (snap_gen),
        .o_snap_valid (snap_valid),
        .i_snap_ready (snap_ready),
        .o_snap_drop  (snap_drop),
        .o_status     (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] life_step(input logic [63:0] g);
        logic [63:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                            (c + dc) >= 0 && (c + dc) < 8) begin
                            if (g[(r + dr) * 8 + (c + dc)]) cnt++;
                        end
                    end
                end
                n[r * 8 + c] = g[r * 8 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    task automatic build_gens(input logic [63:0] seed);
        gens[0] = seed;
        for (int i = 1; i < MAXG; i++) gens[i] = life_step(gens[i-1]);
    endtask

    // First generation k>=1 that ends the run, and why.
    task automatic model_stop(input logic [15:0] limit, output int k, output logic [1:0] st);
        bit found;
        found = 0;
        k = MAXG - 1;
        st = 2'b00;
        for (int i = 1; i < MAXG; i++) begin
            if (!found) begin
                if (gens[i] == 64'd0) begin
                    k = i; st = 2'b10; found = 1;
                end else if (gens[i] == gens[i-1]) begin
                    k = i; st = 2'b11; found = 1;
                end else if (limit != 0 && i == int'(limit)) begin
                    k = i; st = 2'b01; found = 1;
                end
            end
        end
    endtask

    // One full run with snap_ready held high, checked every cycle after start.
    task automatic do_run(input logic [15:0] limit, output int k_stop, output logic [1:0] st_stop);
        int gi;
        int eg;
        bit ev;
        model_stop(limit, k_stop, st_stop);
        @(negedge clk);
        start = 1'b1; gen_limit = limit; alive_in = gens[0]; snap_ready = 1'b1;
        for (int t = 1; t <= 7 + PL * k_stop; t++) begin
            @(negedge clk);
            start = 1'b0;
            check("busy", busy, 64'(t <= 4 + PL * k_stop));
            check("cell_nrst", cell_nrst, 64'(t >= 3));
            check("seed_en", seed_en, 64'(t == 3));
            eg = (t >= 5) ? (t - 5) / PL : 0;
            if (eg > k_stop) eg = k_stop;
            check("gen_cnt", gen_cnt, 64'(eg));
            check("status", status, (t >= 5 + PL * k_stop) ? 64'(st_stop) : 64'd0);
            check("snap_drop", snap_drop, 64'd0);
            ev = (t >= 5) && ((t - 5) % PL == 0) && ((t - 5) / PL <= k_stop);
            check("snap_valid", snap_valid, 64'(ev));
            if (ev) begin
                check("snap_gen", snap_gen, 64'((t - 5) / PL));
                check("snap_data", snap_data, gens[(t - 5) / PL]);
            end
            gi = (t >= 4) ? (t - 4) / PL : 0;
            if (gi > MAXG - 1) gi = MAXG - 1;
            alive_in = gens[gi];
        end
    endtask

    typedef struct {
        int          seed_id;
        logic [15:0] limit;
        logic [1:0]  exp_status;
        int          exp_gen;
    } vec_t;

    localparam int NV = 7;
    vec_t        vecs [NV];
    logic [63:0] seeds [5];

    initial begin
        int          k;
        logic [1:0]  st;
        logic [15:0] lim;
        int          j;
        int          gi;

        rst = 1'b1; start = 1'b0; abort = 1'b0; gen_limit = '0; alive_in = '0;
        snap_ready = 1'b0;

        // Seeds on an 8x8 grid, bit index row*8+col.
        seeds[0] = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);             // blinker
        seeds[1] = 64'd1 << 36;                                                // lone cell
        seeds[2] = (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36); // block
        seeds[3] = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) | (64'd1 << 17) |
                   (64'd1 << 18);                                              // glider
        seeds[4] = 64'd0;                                                      // empty

        vecs[0] = '{seed_id: 0, limit: 16'd5, exp_status: 2'b01, exp_gen: 5};
        vecs[1] = '{seed_id: 1, limit: 16'd0, exp_status: 2'b10, exp_gen: 1};
        vecs[2] = '{seed_id: 2, limit: 16'd0, exp_status: 2'b11, exp_gen: 1};
        vecs[3] = '{seed_id: 3, limit: 16'd3, exp_status: 2'b01, exp_gen: 3};
        vecs[4] = '{seed_id: 1, limit: 16'd1, exp_status: 2'b10, exp_gen: 1};
        vecs[5] = '{seed_id: 2, limit: 16'd1, exp_status: 2'b11, exp_gen: 1};
        vecs[6] = '{seed_id: 4, limit: 16'd4, exp_status: 2'b10, exp_gen: 1};

        repeat (3) @(negedge clk);
        check("rst_cell_nrst", cell_nrst, 64'd0);
        check("rst_seed_en", seed_en, 64'd0);
        check("rst_busy", busy, 64'd0);
        check("rst_gen_cnt", gen_cnt, 64'd0);
        check("rst_snap_valid", snap_valid, 64'd0);
        check("rst_snap_data", snap_data, 64'd0);
        check("rst_snap_gen", snap_gen, 64'd0);
        check("rst_snap_drop", snap_drop, 64'd0);
        check("rst_status", status, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            build_gens(seeds[vecs[i].seed_id]);
            do_run(vecs[i].limit, k, st);
            check("tbl_status", status, 64'(vecs[i].exp_status));
            check("tbl_gen_cnt", gen_cnt, 64'(vecs[i].exp_gen));
        end

        // Consumer stalled over three captures: last one kept, drop flagged.
        build_gens(seeds[0]);
        @(negedge clk);
        start = 1'b1; gen_limit = 16'd2; alive_in = gens[0]; snap_ready = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            start = 1'b0;
            gi = (t >= 4) ? (t - 4) / PL : 0;
            alive_in = gens[gi];
        end
        check("drop_valid", snap_valid, 64'd1);
        check("drop_gen", snap_gen, 64'd2);
        check("drop_data", snap_data, gens[2]);
        check("drop_flag", snap_drop, 64'd1);
        check("drop_status", status, 64'd1);
        snap_ready = 1'b1;
        @(negedge clk);
        snap_ready = 1'b0;
        check("drop_valid_fall", snap_valid, 64'd0);
        check("drop_flag_sticky", snap_drop, 64'd1);

        // Restart clears the drop flag (checked inside do_run).
        build_gens(seeds[2]);
        do_run(16'd0, k, st);

        // Start while busy is ignored; abort in RUN phase 3 of generation 1.
        build_gens(seeds[0]);
        @(negedge clk);
        start = 1'b1; gen_limit = 16'd0; alive_in = gens[0]; snap_ready = 1'b0;
        for (int t = 1; t <= 14; t++) begin
            @(negedge clk);
            start = (t == 2);
            if (t == 3) check("busy_start_seed", seed_en, 64'd1);
            if (t == 4) check("busy_start_run", seed_en, 64'd0);
            if (t == 14) begin
                check("abort_pre_gen", gen_cnt, 64'd1);
                abort = 1'b1;
            end
            gi = (t >= 4) ? (t - 4) / PL : 0;
            alive_in = gens[gi];
        end
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 64'd0);
        check("abort_cell_nrst", cell_nrst, 64'd0);
        check("abort_snap_kept", snap_valid, 64'd1);
        check("abort_snap_gen", snap_gen, 64'd1);
        check("abort_status", status, 64'd0);
        check("abort_gen_cnt", gen_cnt, 64'd1);
        repeat (3) @(negedge clk);
        check("abort_idle_hold", cell_nrst, 64'd0);
        snap_ready = 1'b1;
        @(negedge clk);
        snap_ready = 1'b0;
        build_gens(seeds[0]);
        do_run(16'd2, k, st);
        check("rerun_gen_cnt", gen_cnt, 64'd2);

        // Synchronous reset mid-run.
        build_gens(seeds[3]);
        @(negedge clk);
        start = 1'b1; gen_limit = 16'd0; alive_in = gens[0];
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 64'd0);
        check("midrst_cell_nrst", cell_nrst, 64'd0);
        check("midrst_snap_valid", snap_valid, 64'd0);
        check("midrst_gen_cnt", gen_cnt, 64'd0);

        // Random generation sequences against the list model.
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < MAXG; i++) gens[i] = {$urandom(), $urandom()};
            lim = 16'($urandom_range(0, 8));
            if ($urandom_range(0, 1) == 1) begin
                j = $urandom_range(1, 9);
                if ($urandom_range(0, 1) == 1) gens[j] = '0;
                else gens[j] = gens[j-1];
            end
            if (lim == 0) gens[10] = gens[9];
            do_run(lim, k, st);
            check("rnd_status", status, 64'(st));
            check("rnd_gen_cnt", gen_cnt, 64'(k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
